// File: rtl/coef_matrix_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coef_matrix_buffer                                                         |
// | Double-buffered 8x8 coefficient store between computeCoef and the IDCT.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coef_matrix_buffer #(
   parameter int COEF_W = 12,
   parameter int BLK_W  = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_write,
   input  logic [5:0]        i_writeIdx,
   input  logic [BLK_W-1:0]  i_blockNum,
   input  logic [COEF_W-1:0] i_coefValue,
   input  logic              i_matrixComplete,
   output logic              o_freezePipe,
   output logic              o_bankReady,
   output logic [BLK_W-1:0]  o_bankBlockNum,
   input  logic [5:0]        i_readAdr,
   output logic [COEF_W-1:0] o_readValue,
   input  logic              i_readDone
);

   typedef enum logic [0:0] {
      WRITABLE = 1'b0,
      FULL     = 1'b1
   } bankState_t;

   bankState_t        r_state [2];
   bankState_t        w_stateNext [2];
   logic              r_wrBank;
   logic              r_rdBank;
   logic              w_wrBankNext;
   logic              r_rdBankNextUnused;
   logic              w_rdBankNext;
   logic [63:0]       r_mask [2];
   logic [BLK_W-1:0]  r_tag [2];
   logic [COEF_W-1:0] r_mem [2][64];
   logic [COEF_W-1:0] r_readValue;

   logic              w_acceptWr;
   logic              w_acceptCmp;
   logic              w_release;

   // Freeze depends only on registered state so upstream never sees a loop.
   assign o_freezePipe   = (r_state[r_wrBank] == FULL);
   assign o_bankReady    = (r_state[r_rdBank] == FULL);
   assign o_bankBlockNum = r_tag[r_rdBank];
   assign o_readValue    = r_readValue;

   assign w_acceptWr  = i_write & ~o_freezePipe;
   assign w_acceptCmp = i_matrixComplete & ~o_freezePipe;
   assign w_release   = i_readDone & o_bankReady;

   always_comb begin
      w_stateNext[0]     = r_state[0];
      w_stateNext[1]     = r_state[1];
      w_wrBankNext       = r_wrBank;
      w_rdBankNext       = r_rdBank;
      r_rdBankNextUnused = 1'b0;
      // Complete and release can never target the same bank, so both may apply.
      if (w_acceptCmp) begin
         w_stateNext[r_wrBank] = FULL;
         w_wrBankNext          = ~r_wrBank;
      end
      if (w_release) begin
         w_stateNext[r_rdBank] = WRITABLE;
         w_rdBankNext          = ~r_rdBank;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state[0] <= WRITABLE;
         r_state[1] <= WRITABLE;
         r_wrBank   <= 1'b0;
         r_rdBank   <= 1'b0;
      end else begin
         r_state[0] <= w_stateNext[0];
         r_state[1] <= w_stateNext[1];
         r_wrBank   <= w_wrBankNext;
         r_rdBank   <= w_rdBankNext | r_rdBankNextUnused;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mask[0]   <= '0;
         r_mask[1]   <= '0;
         r_tag[0]    <= '0;
         r_tag[1]    <= '0;
         r_readValue <= '0;
      end else begin
         if (w_acceptWr) begin
            r_mask[r_wrBank][i_writeIdx] <= 1'b1;
            r_tag[r_wrBank]              <= i_blockNum;
         end
         if (w_acceptCmp) begin
            r_tag[r_wrBank] <= i_blockNum;
         end
         if (w_release) begin
            r_mask[r_rdBank] <= '0;
         end
         // Unwritten entries are masked to zero rather than clearing the RAM.
         r_readValue <= r_mask[r_rdBank][i_readAdr] ? r_mem[r_rdBank][i_readAdr] : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_acceptWr) begin
         r_mem[r_wrBank][i_writeIdx] <= i_coefValue;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_coef_matrix_buffer.sv
`default_nettype none
// Testbench for coef_matrix_buffer: fixed vector table, directed corner sequences,
// then random traffic against a queue-of-blocks reference model.
module tb_coef_matrix_buffer;

   localparam int COEF_W = 12;
   localparam int BLK_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              write;
   logic [5:0]        writeIdx;
   logic [BLK_W-1:0]  blockNum;
   logic [COEF_W-1:0] coefValue;
   logic              matrixComplete;
   logic              freezePipe;
   logic              bankReady;
   logic [BLK_W-1:0]  bankBlockNum;
   logic [5:0]        readAdr;
   logic [COEF_W-1:0] readValue;
   logic              readDone;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   coef_matrix_buffer #(.COEF_W(COEF_W), .BLK_W(BLK_W)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_write(write),
      .i_writeIdx(writeIdx),
      .i_blockNum(blockNum),
      .i_coefValue(coefValue),
      .i_matrixComplete(matrixComplete),
      .o_freezePipe(freezePipe),
      .o_bankReady(bankReady),
      .o_bankBlockNum(bankBlockNum),
      .i_readAdr(readAdr),
      .o_readValue(readValue),
      .i_readDone(readDone)
   );

   // Reference model: completed blocks in a FIFO (max 2) plus the block being filled.
   typedef struct packed {
      logic [BLK_W-1:0]     tag;
      logic [64*COEF_W-1:0] d;
   } blk_t;

   blk_t                 q[$];
   logic [64*COEF_W-1:0] curD;

   typedef struct {
      logic              wr;
      logic [5:0]        idx;
      logic [BLK_W-1:0]  blk;
      logic [COEF_W-1:0] val;
      logic              cmp;
      logic [5:0]        radr;
      logic              rdone;
      logic              eFrz;
      logic              eRdy;
      logic [BLK_W-1:0]  eTag;
      logic              chkRd;
      logic [COEF_W-1:0] eRd;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic r, input logic wr, input logic [5:0] idx,
                      input logic [BLK_W-1:0] blk, input logic [COEF_W-1:0] val,
                      input logic cmp, input logic [5:0] radr, input logic rdone);
      rst            = r;
      write          = wr;
      writeIdx       = idx;
      blockNum       = blk;
      coefValue      = val;
      matrixComplete = cmp;
      readAdr        = radr;
      readDone       = rdone;
   endtask

   // One clock with model prediction and output checks.
   task automatic cyc(input logic r, input logic wr, input logic [5:0] idx,
                      input logic [BLK_W-1:0] blk, input logic [COEF_W-1:0] val,
                      input logic cmp, input logic [5:0] radr, input logic rdone);
      bit                frz;
      bit                rdy;
      logic [COEF_W-1:0] expRd;
      frz   = (q.size() == 2);
      rdy   = (q.size() > 0);
      expRd = rdy ? q[0].d[int'(radr)*COEF_W +: COEF_W] : '0;
      drv(r, wr, idx, blk, val, cmp, radr, rdone);
      if (r) begin
         q.delete();
         curD = '0;
      end else begin
         if (!frz && wr) curD[int'(idx)*COEF_W +: COEF_W] = val;
         if (!frz && cmp) begin
            q.push_back('{tag: blk, d: curD});
            curD = '0;
         end
         if (rdone && rdy) void'(q.pop_front());
      end
      @(posedge clk);
      #1;
      chk("freeze", 32'(freezePipe), 32'(q.size() == 2));
      chk("ready", 32'(bankReady), 32'(q.size() > 0));
      if (r) begin
         chk("rst_tag", 32'(bankBlockNum), 32'd0);
         chk("rst_read", 32'(readValue), 32'd0);
      end else begin
         if (q.size() > 0) chk("tag", 32'(bankBlockNum), 32'(q[0].tag));
         if (rdy) chk("read", 32'(readValue), 32'(expRd));
      end
   endtask

   task automatic idle(input logic [5:0] radr, input logic rdone);
      cyc(0, 0, 0, 0, 0, 0, radr, rdone);
   endtask

   initial begin
      curD = '0;
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_freeze", 32'(freezePipe), 32'd0);
      chk("reset_ready", 32'(bankReady), 32'd0);
      chk("reset_tag", 32'(bankBlockNum), 32'd0);
      chk("reset_read", 32'(readValue), 32'd0);

      // wr idx blk val cmp radr rdone | frz rdy tag chkRd rd
      vecs[0]  = '{1, 0,  3, 12'd5,   0, 0,  0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 63, 3, 12'h800, 0, 0,  0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0,  3, 0,       1, 0,  0, 0, 1, 3, 0, 0};
      vecs[3]  = '{0, 0,  0, 0,       0, 0,  0, 0, 1, 3, 1, 12'd5};
      vecs[4]  = '{0, 0,  0, 0,       0, 63, 0, 0, 1, 3, 1, 12'h800};
      vecs[5]  = '{0, 0,  0, 0,       0, 10, 0, 0, 1, 3, 1, 12'd0};
      vecs[6]  = '{1, 7,  1, 12'd100, 0, 0,  0, 0, 1, 3, 1, 12'd5};
      vecs[7]  = '{1, 7,  1, 12'hFFF, 0, 0,  0, 0, 1, 3, 1, 12'd5};
      vecs[8]  = '{0, 0,  1, 0,       1, 0,  0, 1, 1, 3, 1, 12'd5};
      vecs[9]  = '{0, 0,  0, 0,       0, 7,  1, 0, 1, 1, 1, 12'd0};
      vecs[10] = '{0, 0,  0, 0,       0, 7,  0, 0, 1, 1, 1, 12'hFFF};
      vecs[11] = '{0, 0,  5, 0,       1, 7,  0, 1, 1, 1, 1, 12'hFFF};
      vecs[12] = '{0, 0,  0, 0,       0, 7,  1, 0, 1, 5, 1, 12'hFFF};
      vecs[13] = '{0, 0,  0, 0,       0, 7,  0, 0, 1, 5, 1, 12'd0};
      vecs[14] = '{0, 0,  0, 0,       0, 0,  0, 0, 1, 5, 1, 12'd0};
      vecs[15] = '{0, 0,  0, 0,       0, 0,  1, 0, 0, 5, 0, 12'd0};

      for (int i = 0; i < 16; i++) begin
         drv(0, vecs[i].wr, vecs[i].idx, vecs[i].blk, vecs[i].val, vecs[i].cmp,
             vecs[i].radr, vecs[i].rdone);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_freeze", i), 32'(freezePipe), 32'(vecs[i].eFrz));
         chk($sformatf("vec%0d_ready", i), 32'(bankReady), 32'(vecs[i].eRdy));
         if (vecs[i].eRdy) chk($sformatf("vec%0d_tag", i), 32'(bankBlockNum), 32'(vecs[i].eTag));
         if (vecs[i].chkRd) chk($sformatf("vec%0d_read", i), 32'(readValue), 32'(vecs[i].eRd));
      end

      // Model-tracked phase starts from a clean reset.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // Two blocks buffered: freeze, ignored writes, release, then third block stored.
      cyc(0, 1, 2, 1, 12'd11, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 0, 0);
      cyc(0, 1, 3, 2, 12'd22, 1, 2, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 6'(i + 10), 4, 12'h7AA, 0, 2, 0);
      cyc(0, 0, 0, 0, 0, 0, 2, 1);
      cyc(0, 1, 4, 4, 12'd44, 0, 3, 0);
      cyc(0, 1, 5, 4, 12'h9AB, 0, 3, 0);
      for (int i = 0; i < 6; i++) idle(6'(i + 1), 0);
      // readDone and complete(+write) in the same cycle.
      cyc(0, 1, 63, 6, 12'h123, 1, 10, 1);
      for (int i = 0; i < 64; i++) idle(6'(i), 0);
      idle(0, 1);
      for (int i = 0; i < 64; i++) idle(6'(i), 0);
      idle(0, 1);
      // Empty block completes straight away.
      cyc(0, 0, 0, 5, 0, 1, 0, 0);
      for (int i = 0; i < 64; i += 9) idle(6'(i), 0);
      idle(0, 1);

      // Reset mid-fill and while a bank is ready.
      cyc(0, 1, 20, 2, 12'h555, 0, 0, 0);
      cyc(0, 0, 0, 2, 0, 1, 0, 0);
      cyc(0, 1, 21, 3, 12'h666, 0, 20, 0);
      cyc(1, 0, 0, 0, 0, 0, 20, 0);
      cyc(0, 1, 1, 7, 12'h0AB, 0, 0, 0);
      cyc(0, 0, 0, 7, 0, 1, 0, 0);
      for (int i = 0; i < 64; i++) idle(6'(i), 0);
      idle(0, 1);

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         cyc(($urandom % 300) == 0,
             ($urandom % 2) == 0,
             6'($urandom),
             BLK_W'($urandom),
             COEF_W'($urandom),
             ($urandom % 10) == 0,
             6'($urandom),
             ($urandom % 5) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
